// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: opcodes, operand-use decode,
// width helpers and the priority-winner encoding.
package hazard_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic rs1;
    logic rs2;
  } rs_use_t;

  // Which control branch owns the pipeline this cycle.
  typedef enum logic [2:0] {
    WIN_NONE, WIN_JUMP, WIN_MEM, WIN_HAZARD, WIN_EXT, WIN_INVALID
  } win_e;

  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int ra_width(input int num_regs);
    return clog2_min1(num_regs);
  endfunction

  function automatic int lat_width(input int max_lat);
    return clog2_min1(max_lat + 1);
  endfunction

  function automatic rs_use_t decode_rs_used(input logic [6:0] opcode);
    rs_use_t u;
    u.rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    u.rs1 = u.rs2 || (opcode == OP_IMM) || (opcode == OP_LOAD) || (opcode == OP_JALR);
    return u;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: cycles remaining until a register's pending result
// is forwardable. Load wins over decrement; freeze holds everything.
module sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_freeze,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  output logic [LAT_W-1:0] o_cnt
);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_freeze) begin
      if (i_load) begin
        r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency scoreboard plus pipeline control resolution for a 5-stage core.
// Define HAZARD_SCOREBOARD_PERF_EN to add saturating performance counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int MAX_LAT  = 7,
  localparam int RA_W     = ra_width(NUM_REGS),
  localparam int LAT_W    = lat_width(MAX_LAT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             jump_branch_taken,
  input  logic             mem_read_write,
  input  logic             ext_stall,
  input  logic             invalid_inst,
  output logic             if_id_pipeline_flush,
  output logic             if_id_pipeline_en,
  output logic             id_ex_pipeline_flush,
  output logic             id_ex_pipeline_en,
  output logic             ex_mem_pipeline_flush,
  output logic             mem_wb_pipeline_en,
  output logic             pc_en,
  output logic             raw_stall,
  output logic             waw_stall,
`ifdef HAZARD_SCOREBOARD_PERF_EN
  output logic [31:0]      perf_raw_cyc,
  output logic [31:0]      perf_waw_cyc,
  output logic [31:0]      perf_mem_cyc,
  output logic [31:0]      perf_flush_cnt,
`endif
  output logic             sb_busy
);

  localparam int SLOTS = 2 ** RA_W;

  logic [LAT_W-1:0] w_cnt [SLOTS];
  logic [SLOTS-1:0] w_pending;
  logic [LAT_W-1:0] w_lat;
  rs_use_t          w_use;
  logic             w_raw;
  logic             w_waw;
  logic             w_issue;
  logic             w_do_load;
  win_e             w_win;

  assign w_lat     = (int'(id_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : id_lat;
  assign w_use     = decode_rs_used(id_opcode);
  assign w_raw     = id_valid & ((w_use.rs1 & (w_cnt[id_rs1] != '0)) |
                                 (w_use.rs2 & (w_cnt[id_rs2] != '0)));
  assign w_waw     = id_valid & (id_rd != '0) & (w_lat < w_cnt[id_rd]);
  assign w_issue   = id_valid & ~jump_branch_taken & ~mem_read_write & ~w_raw &
                     ~w_waw & ~ext_stall & ~invalid_inst;
  assign w_do_load = w_issue & (id_rd != '0) & (w_lat != '0);

  // Slot 0 and any address beyond NUM_REGS-1 are hardwired idle.
  for (genvar r = 0; r < SLOTS; r++) begin : g_slot
    if (r == 0 || r >= NUM_REGS) begin : g_idle
      assign w_cnt[r] = '0;
    end else begin : g_entry
      sb_entry #(.LAT_W(LAT_W)) u_entry (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_freeze   (mem_read_write),
        .i_load     (w_do_load & (id_rd == RA_W'(r))),
        .i_load_val (w_lat),
        .o_cnt      (w_cnt[r])
      );
    end
    assign w_pending[r] = (w_cnt[r] != '0);
  end

  assign sb_busy = |w_pending;

  always_comb begin
    w_win = WIN_NONE;
    if (jump_branch_taken)   w_win = WIN_JUMP;
    else if (mem_read_write) w_win = WIN_MEM;
    else if (w_raw | w_waw)  w_win = WIN_HAZARD;
    else if (ext_stall)      w_win = WIN_EXT;
    else if (invalid_inst)   w_win = WIN_INVALID;
  end

  always_comb begin
    if_id_pipeline_flush  = 1'b0;
    if_id_pipeline_en     = 1'b1;
    id_ex_pipeline_flush  = 1'b0;
    id_ex_pipeline_en     = 1'b1;
    ex_mem_pipeline_flush = 1'b0;
    mem_wb_pipeline_en    = 1'b1;
    pc_en                 = 1'b1;
    raw_stall             = 1'b0;
    waw_stall             = 1'b0;
    case (w_win)
      WIN_JUMP: begin
        if_id_pipeline_flush = 1'b1;
        if_id_pipeline_en    = 1'b0;
        id_ex_pipeline_flush = 1'b1;
      end
      WIN_MEM: begin
        if_id_pipeline_en     = 1'b0;
        id_ex_pipeline_en     = 1'b0;
        pc_en                 = 1'b0;
        ex_mem_pipeline_flush = 1'b1;
        mem_wb_pipeline_en    = 1'b0;
      end
      WIN_HAZARD: begin
        if_id_pipeline_en    = 1'b0;
        id_ex_pipeline_flush = 1'b1;
        pc_en                = 1'b0;
        raw_stall            = w_raw;
        waw_stall            = w_waw & ~w_raw;
      end
      WIN_EXT: begin
        if_id_pipeline_en = 1'b0;
        id_ex_pipeline_en = 1'b0;
        pc_en             = 1'b0;
      end
      WIN_INVALID: id_ex_pipeline_flush = 1'b1;
      default: ;
    endcase
  end

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] r_perf_raw_cyc;
  logic [31:0] r_perf_waw_cyc;
  logic [31:0] r_perf_mem_cyc;
  logic [31:0] r_perf_flush_cnt;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_raw_cyc   <= '0;
      r_perf_waw_cyc   <= '0;
      r_perf_mem_cyc   <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (raw_stall && r_perf_raw_cyc != '1)            r_perf_raw_cyc   <= r_perf_raw_cyc + 1'b1;
      if (waw_stall && r_perf_waw_cyc != '1)            r_perf_waw_cyc   <= r_perf_waw_cyc + 1'b1;
      if (w_win == WIN_MEM && r_perf_mem_cyc != '1)     r_perf_mem_cyc   <= r_perf_mem_cyc + 1'b1;
      if (jump_branch_taken && r_perf_flush_cnt != '1)  r_perf_flush_cnt <= r_perf_flush_cnt + 1'b1;
    end
  end

  assign perf_raw_cyc   = r_perf_raw_cyc;
  assign perf_waw_cyc   = r_perf_waw_cyc;
  assign perf_mem_cyc   = r_perf_mem_cyc;
  assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; the perf section is active only when
// HAZARD_SCOREBOARD_PERF_EN is defined.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_lat;
  logic       jump_branch_taken, mem_read_write, ext_stall, invalid_inst;
  logic       if_id_pipeline_flush, if_id_pipeline_en;
  logic       id_ex_pipeline_flush, id_ex_pipeline_en;
  logic       ex_mem_pipeline_flush, mem_wb_pipeline_en, pc_en;
  logic       raw_stall, waw_stall, sb_busy;
`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] perf_raw_cyc, perf_waw_cyc, perf_mem_cyc, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OPR   = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] OPLD  = 7'b0000011;

  // Packed expected view: {if_id_flush, if_id_en, id_ex_flush, id_ex_en,
  // ex_mem_flush, mem_wb_en, pc_en, raw_stall, waw_stall, sb_busy}
  localparam logic [9:0] IDLE  = 10'b0101011000;
  localparam logic [9:0] BUSY  = 10'b0101011001;
  localparam logic [9:0] RAW   = 10'b0011010101;
  localparam logic [9:0] WAW   = 10'b0011010011;
  localparam logic [9:0] MEMB  = 10'b0000100001;
  localparam logic [9:0] JMPB  = 10'b1011011001;
  localparam logic [9:0] EXTI  = 10'b0000010000;
  localparam logic [9:0] INVI  = 10'b0111011000;

  hazard_scoreboard dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .id_valid              (id_valid),
    .id_opcode             (id_opcode),
    .id_rs1                (id_rs1),
    .id_rs2                (id_rs2),
    .id_rd                 (id_rd),
    .id_lat                (id_lat),
    .jump_branch_taken     (jump_branch_taken),
    .mem_read_write        (mem_read_write),
    .ext_stall             (ext_stall),
    .invalid_inst          (invalid_inst),
    .if_id_pipeline_flush  (if_id_pipeline_flush),
    .if_id_pipeline_en     (if_id_pipeline_en),
    .id_ex_pipeline_flush  (id_ex_pipeline_flush),
    .id_ex_pipeline_en     (id_ex_pipeline_en),
    .ex_mem_pipeline_flush (ex_mem_pipeline_flush),
    .mem_wb_pipeline_en    (mem_wb_pipeline_en),
    .pc_en                 (pc_en),
    .raw_stall             (raw_stall),
    .waw_stall             (waw_stall),
`ifdef HAZARD_SCOREBOARD_PERF_EN
    .perf_raw_cyc          (perf_raw_cyc),
    .perf_waw_cyc          (perf_waw_cyc),
    .perf_mem_cyc          (perf_mem_cyc),
    .perf_flush_cnt        (perf_flush_cnt),
`endif
    .sb_busy               (sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge; outputs are checked 1ns later.
  task automatic applyStimulus(input logic v, input logic [6:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [2:0] lat,
                               input logic jb, input logic mem,
                               input logic ext, input logic inv);
    @(negedge clk);
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_lat = lat; jump_branch_taken = jb; mem_read_write = mem;
    ext_stall = ext; invalid_inst = inv;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] expected);
    logic [9:0] observed;
    observed = {if_id_pipeline_flush, if_id_pipeline_en, id_ex_pipeline_flush,
                id_ex_pipeline_en, ex_mem_pipeline_flush, mem_wb_pipeline_en,
                pc_en, raw_stall, waw_stall, sb_busy};
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_lat = '0; jump_branch_taken = 0; mem_read_write = 0;
    ext_stall = 0; invalid_inst = 0;
    #3;
    checkOutput("reset_state", IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // load x5 (lat 2) then dependent add stalls two cycles
    applyStimulus(1, OPLD, 5'd1, 5'd0, 5'd5, 3'd2, 0, 0, 0, 0);
    checkOutput("ld_x5_issue", IDLE);
    applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    checkOutput("raw_cyc1", RAW);
    applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    checkOutput("raw_cyc2", RAW);
    applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    checkOutput("raw_issue", IDLE);

    // div x7 (lat 7) then lat-1 write to x7: waw while cnt[x7] >= 2
    applyStimulus(1, OPR, 5'd0, 5'd0, 5'd7, 3'd7, 0, 0, 0, 0);
    checkOutput("div_issue", IDLE);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, OPIMM, 5'd0, 5'd0, 5'd7, 3'd1, 0, 0, 0, 0);
      checkOutput($sformatf("waw_wait%0d", i), WAW);
    end
    applyStimulus(1, OPIMM, 5'd0, 5'd0, 5'd7, 3'd1, 0, 0, 0, 0);
    checkOutput("waw_issue", BUSY);
    applyStimulus(0, OPIMM, 5'd0, 5'd0, 5'd0, 3'd0, 0, 0, 0, 0);
    checkOutput("x7_reloaded", BUSY);
    applyStimulus(0, OPIMM, 5'd0, 5'd0, 5'd0, 3'd0, 0, 0, 0, 0);
    checkOutput("x7_drained", IDLE);

    // memory busy freezes cnt[x5]=2 for three cycles
    applyStimulus(1, OPLD, 5'd1, 5'd0, 5'd5, 3'd2, 0, 0, 0, 0);
    checkOutput("ld_x5_again", IDLE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 0, 1, 0, 0);
      checkOutput($sformatf("mem_busy%0d", i), MEMB);
    end
    applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    checkOutput("frozen_raw1", RAW);
    applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    checkOutput("frozen_raw2", RAW);
    applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    checkOutput("frozen_issue", IDLE);

    // jump beats raw; cnt[x5] (3) keeps draining during the jump
    applyStimulus(1, OPLD, 5'd1, 5'd0, 5'd5, 3'd3, 0, 0, 0, 0);
    checkOutput("ld_x5_lat3", IDLE);
    applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 1, 0, 0, 0);
    checkOutput("jump_over_raw", JMPB);
    applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    checkOutput("post_jump_raw1", RAW);
    applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    checkOutput("post_jump_raw2", RAW);
    applyStimulus(1, OPR, 5'd5, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    checkOutput("post_jump_issue", IDLE);

    applyStimulus(1, OPR, 5'd1, 5'd2, 5'd8, 3'd0, 0, 0, 1, 0);
    checkOutput("ext_stall", EXTI);
    applyStimulus(1, OPR, 5'd1, 5'd2, 5'd8, 3'd0, 0, 0, 0, 1);
    checkOutput("invalid_inst", INVI);

    // rd=x0 never becomes pending
    applyStimulus(1, OPR, 5'd1, 5'd2, 5'd0, 3'd5, 0, 0, 0, 0);
    checkOutput("rd0_issue", IDLE);
    applyStimulus(0, OPR, 5'd0, 5'd0, 5'd0, 3'd0, 0, 0, 0, 0);
    checkOutput("rd0_not_busy", IDLE);

    // reset while cnt[x3]=4 clears everything asynchronously
    applyStimulus(1, OPLD, 5'd1, 5'd0, 5'd3, 3'd4, 0, 0, 0, 0);
    checkOutput("ld_x3_issue", IDLE);
    applyStimulus(0, OPR, 5'd0, 5'd0, 5'd0, 3'd0, 0, 0, 0, 0);
    checkOutput("x3_pending", BUSY);
    #1 rst_n = 1'b0;
    #1 checkOutput("async_clear", IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, OPR, 5'd3, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    checkOutput("post_reset_no_raw", IDLE);

`ifdef HAZARD_SCOREBOARD_PERF_EN
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, OPLD, 5'd1, 5'd0, 5'd9, 3'd5, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1, OPR, 5'd9, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
        checkOutput("perf_raw_step", RAW);
      end
      applyStimulus(1, OPR, 5'd9, 5'd1, 5'd6, 3'd0, 0, 0, 0, 0);
    end
    checkValue("perf_raw_cyc", perf_raw_cyc, 32'd10);
    force dut.r_perf_flush_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.r_perf_flush_cnt;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, OPR, 5'd0, 5'd0, 5'd0, 3'd0, 1, 0, 0, 0);
    end
    checkValue("perf_flush_sat", perf_flush_cnt, 32'hFFFF_FFFF);
`endif

    applyStimulus(0, OPR, 5'd0, 5'd0, 5'd0, 3'd0, 0, 0, 0, 0);
    checkOutput("final_idle", IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
